// File: rtl/ip_ttl_update.sv
// ip_ttl_update
//   Forwarding-path rewrite stage. On the first beat of each packet it
//   decrements the IPv4 TTL and incrementally patches the header checksum
//   (RFC 1624) when the packet is IPv4, has TTL >= 2 and is headed to one or
//   more MAC ports only. All other beats and packets pass through bit-exact.
//   AXI4-Stream register stage with a one-entry skid buffer, 1 beat/cycle.
//
// Ports
//   AXI_ACLK, reset           clock, synchronous active-high reset
//   S_AXIS_T*                 input stream (TREADY registered, = !skid full)
//   M_AXIS_T*                 output stream (registered, 1-cycle latency)
//   counters_clear            synchronous clear of both counters (wins)
//   ttl_dec_count             packets rewritten
//   bypass_count              packets forwarded unmodified
module ip_ttl_update #(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int DST_PORT_POS         = 24
) (
  input  logic                              AXI_ACLK,
  input  logic                              reset,

  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,

  output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                              M_AXIS_TVALID,
  input  logic                              M_AXIS_TREADY,
  output logic                              M_AXIS_TLAST,

  input  logic                              counters_clear,
  output logic [31:0]                       ttl_dec_count,
  output logic [31:0]                       bypass_count
);

  // First-beat header field positions (byte 0 at the top of TDATA).
  localparam int ETH_HI  = 159;
  localparam int ETH_LO  = 144;
  localparam int VER_HI  = 143;
  localparam int VER_LO  = 140;
  localparam int TTL_HI  = 79;
  localparam int TTL_LO  = 72;
  localparam int CSUM_HI = 63;
  localparam int CSUM_LO = 48;

  // Odd bits of the one-hot destination field select CPU ports.
  localparam logic [7:0] CPU_PORT_MASK = 8'hAA;

  typedef enum logic {
    HEADER,
    PAYLOAD
  } state_t;

  state_t state_q, state_d;

  // Output register
  logic [C_M_AXIS_DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] out_strb_q, out_strb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  out_user_q, out_user_d;
  logic                             out_last_q, out_last_d;
  logic                             out_valid_q, out_valid_d;

  // Skid register
  logic [C_M_AXIS_DATA_WIDTH-1:0]   skid_data_q, skid_data_d;
  logic [C_M_AXIS_DATA_WIDTH/8-1:0] skid_strb_q, skid_strb_d;
  logic [C_M_AXIS_TUSER_WIDTH-1:0]  skid_user_q, skid_user_d;
  logic                             skid_last_q, skid_last_d;
  logic                             skid_valid_q, skid_valid_d;

  logic                             s_ready_q, s_ready_d;
  logic [31:0]                      ttl_cnt_q, ttl_cnt_d;
  logic [31:0]                      byp_cnt_q, byp_cnt_d;

  // Header inspection and rewrite
  logic                             accept;
  logic                             first_beat;
  logic                             out_free;
  logic [15:0]                      ethertype;
  logic [3:0]                       version;
  logic [7:0]                       ttl;
  logic [15:0]                      csum;
  logic [7:0]                       dst_ports;
  logic                             eligible;
  logic [7:0]                       ttl_new;
  logic [16:0]                      csum_sum;
  logic [15:0]                      csum_new;
  logic [C_S_AXIS_DATA_WIDTH-1:0]   beat_data;

  assign accept     = S_AXIS_TVALID && s_ready_q;
  assign first_beat = (state_q == HEADER);
  assign out_free   = !out_valid_q || M_AXIS_TREADY;

  assign ethertype  = S_AXIS_TDATA[ETH_HI:ETH_LO];
  assign version    = S_AXIS_TDATA[VER_HI:VER_LO];
  assign ttl        = S_AXIS_TDATA[TTL_HI:TTL_LO];
  assign csum       = S_AXIS_TDATA[CSUM_HI:CSUM_LO];
  assign dst_ports  = S_AXIS_TUSER[DST_PORT_POS +: 8];

  assign eligible = (ethertype == 16'h0800) &&
                    (version == 4'd4) &&
                    (ttl >= 8'd2) &&
                    (dst_ports != 8'h00) &&
                    ((dst_ports & CPU_PORT_MASK) == 8'h00);

  // TTL sits in the high byte of its header word, so decrementing it adds
  // 0x0100 to the one's-complement checksum. The end-around carry cannot
  // ripple a second time: with a carry out, s[15:0] is at most 0x00FF.
  assign ttl_new  = ttl - 8'd1;
  assign csum_sum = {1'b0, csum} + 17'h00100;
  assign csum_new = csum_sum[15:0] + {15'd0, csum_sum[16]};

  always_comb begin
    beat_data = S_AXIS_TDATA;
    if (first_beat && eligible) begin
      beat_data[TTL_HI:TTL_LO]   = ttl_new;
      beat_data[CSUM_HI:CSUM_LO] = csum_new;
    end
  end

  // Packet framing
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = S_AXIS_TLAST ? HEADER : PAYLOAD;
    end
  end

  // Output / skid steering. An accept only happens while the skid register is
  // empty (TREADY mirrors its emptiness), so a draining skid beat never
  // collides with a new input beat.
  always_comb begin
    out_data_d   = out_data_q;
    out_strb_d   = out_strb_q;
    out_user_d   = out_user_q;
    out_last_d   = out_last_q;
    out_valid_d  = out_valid_q;
    skid_data_d  = skid_data_q;
    skid_strb_d  = skid_strb_q;
    skid_user_d  = skid_user_q;
    skid_last_d  = skid_last_q;
    skid_valid_d = skid_valid_q;

    if (out_free) begin
      if (skid_valid_q) begin
        out_data_d   = skid_data_q;
        out_strb_d   = skid_strb_q;
        out_user_d   = skid_user_q;
        out_last_d   = skid_last_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_data_d  = beat_data;
        out_strb_d  = S_AXIS_TSTRB;
        out_user_d  = S_AXIS_TUSER;
        out_last_d  = S_AXIS_TLAST;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_data_d  = beat_data;
      skid_strb_d  = S_AXIS_TSTRB;
      skid_user_d  = S_AXIS_TUSER;
      skid_last_d  = S_AXIS_TLAST;
      skid_valid_d = 1'b1;
    end

    s_ready_d = !skid_valid_d;
  end

  // Per-packet counters; clear takes priority over a same-cycle increment.
  always_comb begin
    ttl_cnt_d = ttl_cnt_q;
    byp_cnt_d = byp_cnt_q;
    if (counters_clear) begin
      ttl_cnt_d = '0;
      byp_cnt_d = '0;
    end else if (accept && first_beat) begin
      if (eligible) begin
        ttl_cnt_d = ttl_cnt_q + 32'd1;
      end else begin
        byp_cnt_d = byp_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (reset) begin
      state_q      <= HEADER;
      out_data_q   <= '0;
      out_strb_q   <= '0;
      out_user_q   <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      skid_data_q  <= '0;
      skid_strb_q  <= '0;
      skid_user_q  <= '0;
      skid_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b0;
      ttl_cnt_q    <= '0;
      byp_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_strb_q   <= out_strb_d;
      out_user_q   <= out_user_d;
      out_last_q   <= out_last_d;
      out_valid_q  <= out_valid_d;
      skid_data_q  <= skid_data_d;
      skid_strb_q  <= skid_strb_d;
      skid_user_q  <= skid_user_d;
      skid_last_q  <= skid_last_d;
      skid_valid_q <= skid_valid_d;
      s_ready_q    <= s_ready_d;
      ttl_cnt_q    <= ttl_cnt_d;
      byp_cnt_q    <= byp_cnt_d;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TSTRB  = out_strb_q;
  assign M_AXIS_TUSER  = out_user_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign ttl_dec_count = ttl_cnt_q;
  assign bypass_count  = byp_cnt_q;

endmodule

// File: tb/tb_ip_ttl_update.sv
// Testbench for ip_ttl_update: directed header cases followed by randomized
// mixed traffic under random backpressure, checked against a packet-level
// reference model (expected-beat queue plus counter model).
module tb_ip_ttl_update;

  localparam int DPP = 24;

  logic         AXI_ACLK = 1'b0;
  logic         reset;
  logic [255:0] s_tdata;
  logic [31:0]  s_tstrb;
  logic [127:0] s_tuser;
  logic         s_tvalid;
  logic         s_tready;
  logic         s_tlast;
  logic [255:0] m_tdata;
  logic [31:0]  m_tstrb;
  logic [127:0] m_tuser;
  logic         m_tvalid;
  logic         m_tready;
  logic         m_tlast;
  logic         counters_clear;
  logic [31:0]  ttl_dec_count;
  logic [31:0]  bypass_count;

  ip_ttl_update #(
    .C_S_AXIS_DATA_WIDTH (256),
    .C_M_AXIS_DATA_WIDTH (256),
    .C_S_AXIS_TUSER_WIDTH(128),
    .C_M_AXIS_TUSER_WIDTH(128),
    .DST_PORT_POS        (DPP)
  ) dut (
    .AXI_ACLK      (AXI_ACLK),
    .reset         (reset),
    .S_AXIS_TDATA  (s_tdata),
    .S_AXIS_TSTRB  (s_tstrb),
    .S_AXIS_TUSER  (s_tuser),
    .S_AXIS_TVALID (s_tvalid),
    .S_AXIS_TREADY (s_tready),
    .S_AXIS_TLAST  (s_tlast),
    .M_AXIS_TDATA  (m_tdata),
    .M_AXIS_TSTRB  (m_tstrb),
    .M_AXIS_TUSER  (m_tuser),
    .M_AXIS_TVALID (m_tvalid),
    .M_AXIS_TREADY (m_tready),
    .M_AXIS_TLAST  (m_tlast),
    .counters_clear(counters_clear),
    .ttl_dec_count (ttl_dec_count),
    .bypass_count  (bypass_count)
  );

  always #5 AXI_ACLK = ~AXI_ACLK;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  beat_t       expq[$];
  bit          in_pkt;
  int unsigned m_ttl;
  int unsigned m_byp;
  int          ntot;
  int          npass;
  int          rdy_pct;
  bit          rdy_chk;
  bit          last_acc;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: forwarding rules applied with plain integer arithmetic.
  function automatic logic [255:0] ref_first(input logic [255:0] d, input logic [127:0] u,
                                             output bit elig);
    int   ttl;
    int   cs;
    logic [7:0] dst;
    logic [255:0] r;
    r   = d;
    ttl = int'(d[79:72]);
    cs  = int'(d[63:48]);
    dst = u[DPP +: 8];
    elig = (d[159:144] == 16'h0800) && (d[143:140] == 4'd4) && (ttl >= 2) &&
           (dst != 8'h00) && ((dst & 8'hAA) == 8'h00);
    if (elig) begin
      ttl = ttl - 1;
      cs  = cs + 256;
      if (cs > 65535) cs = cs - 65535;
      r[79:72] = ttl[7:0];
      r[63:48] = cs[15:0];
    end
    return r;
  endfunction

  function automatic logic [255:0] mk_hdr(input logic [15:0] eth, input logic [3:0] ver,
                                          input logic [7:0] ttl, input logic [15:0] cs);
    logic [255:0] d;
    d = rnd256();
    d[159:144] = eth;
    d[143:140] = ver;
    d[79:72]   = ttl;
    d[63:48]   = cs;
    return d;
  endfunction

  function automatic logic [127:0] mk_user(input logic [7:0] dst);
    logic [127:0] u;
    u = rnd128();
    u[DPP +: 8] = dst;
    return u;
  endfunction

  // One clock: sample handshakes before the edge, advance the model, then
  // check DUT state 1 time unit after the edge.
  task automatic tick();
    bit acc;
    bit fire;
    bit first;
    bit elig;
    beat_t b;
    m_tready = ($urandom_range(0, 99) < rdy_pct);
    #1;
    acc  = s_tvalid && s_tready;
    fire = m_tvalid && m_tready;
    b.d = s_tdata; b.s = s_tstrb; b.u = s_tuser; b.l = s_tlast;
    first = !in_pkt;
    elig  = 1'b0;
    if (acc && first) b.d = ref_first(s_tdata, s_tuser, elig);
    if (counters_clear) begin
      m_ttl = 0; m_byp = 0;
    end else if (acc && first) begin
      if (elig) m_ttl++; else m_byp++;
    end
    @(posedge AXI_ACLK);
    #1;
    last_acc = acc;
    if (fire && expq.size() > 0) void'(expq.pop_front());
    if (acc) begin
      expq.push_back(b);
      in_pkt = !b.l;
    end
    chk("m_tvalid", m_tvalid, expq.size() != 0);
    if (expq.size() > 0) begin
      chk("m_tdata", m_tdata, expq[0].d);
      chk("m_tstrb", m_tstrb, expq[0].s);
      chk("m_tuser", m_tuser, expq[0].u);
      chk("m_tlast", m_tlast, expq[0].l);
    end
    if (rdy_chk) chk("s_tready", s_tready, expq.size() < 2);
    chk("ttl_dec_count", ttl_dec_count, m_ttl);
    chk("bypass_count", bypass_count, m_byp);
  endtask

  task automatic send_beat(input logic [255:0] d, input logic [127:0] u, input logic l);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tstrb  = $urandom;
    s_tuser  = u;
    s_tlast  = l;
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_acc && n < 200);
    if (!last_acc) begin
      ntot++;
      $error("FAIL accept_timeout: got no accept after %0d cycles, expected accept", n);
    end
    s_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [255:0] d0, input logic [127:0] u, input int nb, input bit gaps);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) tick();
      send_beat(i == 0 ? d0 : rnd256(), u, i == nb - 1);
    end
  endtask

  task automatic drain();
    int n;
    rdy_pct = 100;
    n = 0;
    while (expq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    chk("drain_empty", expq.size(), 0);
  endtask

  task automatic clear_counters();
    counters_clear = 1'b1;
    tick();
    counters_clear = 1'b0;
  endtask

  logic [255:0] d;
  logic [127:0] u;
  int           kind;

  initial begin
    ntot = 0; npass = 0; rdy_pct = 100; rdy_chk = 0; in_pkt = 0;
    m_ttl = 0; m_byp = 0;
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tstrb = '0; s_tuser = '0;
    s_tlast = 1'b0; m_tready = 1'b1; counters_clear = 1'b0;

    // Reset state
    repeat (3) @(posedge AXI_ACLK);
    #1;
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_s_tready", s_tready, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_ttl_cnt", ttl_dec_count, 0);
    chk("rst_byp_cnt", bypass_count, 0);
    reset = 1'b0;
    @(posedge AXI_ACLK);
    #1;
    chk("post_rst_s_tready", s_tready, 1);
    rdy_chk = 1;

    // Basic rewrite, 3-beat packet, 1-cycle latency
    d = mk_hdr(16'h0800, 4'd4, 8'h40, 16'hB1E6);
    u = mk_user(8'b0000_0100);
    send_beat(d, u, 1'b0);
    chk("lat1_valid", m_tvalid, 1);
    chk("lat1_ttl", m_tdata[79:72], 8'h3F);
    chk("lat1_csum", m_tdata[63:48], 16'hB2E6);
    send_beat(rnd256(), u, 1'b0);
    send_beat(rnd256(), u, 1'b1);
    drain();
    chk("basic_ttl_cnt", ttl_dec_count, 1);

    // Checksum end-around carry
    d = mk_hdr(16'h0800, 4'd4, 8'h05, 16'hFF80);
    send_beat(d, mk_user(8'b0001_0000), 1'b1);
    chk("carry_ttl", m_tdata[79:72], 8'h04);
    chk("carry_csum", m_tdata[63:48], 16'h0081);
    drain();

    // Bypass cases, forwarded bit-exact
    clear_counters();
    d = mk_hdr(16'h0800, 4'd4, 8'h01, 16'h1234);
    send_beat(d, mk_user(8'h01), 1'b0);
    chk("byp_ttl1", m_tdata, d);
    send_beat(rnd256(), '0, 1'b1);
    d = mk_hdr(16'h0806, 4'd4, 8'h40, 16'h1234);
    send_beat(d, mk_user(8'h01), 1'b1);
    chk("byp_arp", m_tdata, d);
    d = mk_hdr(16'h0800, 4'd4, 8'h40, 16'h1234);
    send_beat(d, mk_user(8'b0000_0010), 1'b1);
    chk("byp_cpu", m_tdata, d);
    drain();
    chk("byp_count", bypass_count, 3);
    chk("byp_ttl_count", ttl_dec_count, 0);

    // Back-to-back single-beat packets
    clear_counters();
    for (int i = 0; i < 8; i++) begin
      d = mk_hdr(16'h0800, 4'd4, 8'h10, 16'($urandom));
      send_beat(d, mk_user(8'h01 << (2 * (i % 4))), 1'b1);
      chk("b2b_ttl", m_tdata[79:72], 8'h0F);
    end
    drain();
    chk("b2b_count", ttl_dec_count, 8);

    // Clear coinciding with a first-beat acceptance
    d = mk_hdr(16'h0800, 4'd4, 8'h22, 16'h4000);
    counters_clear = 1'b1;
    send_beat(d, mk_user(8'h04), 1'b0);
    counters_clear = 1'b0;
    chk("clr_ttl_cnt", ttl_dec_count, 0);
    chk("clr_byp_cnt", bypass_count, 0);
    send_beat(rnd256(), '0, 1'b1);
    drain();

    // Randomized mixed traffic under 50% backpressure
    rdy_pct = 50;
    for (int p = 0; p < 1000; p++) begin
      kind = $urandom_range(0, 11);
      d = mk_hdr(16'h0800, 4'd4, 8'($urandom_range(2, 255)), 16'($urandom));
      u = mk_user(8'h01 << (2 * $urandom_range(0, 3)));
      case (kind)
        4: d[79:72] = 8'($urandom_range(0, 1));
        5: d[159:144] = ($urandom_range(0, 1) != 0) ? 16'h0806 : 16'h86DD;
        6: d[143:140] = 4'd6;
        7: u[DPP +: 8] = 8'h02 << (2 * $urandom_range(0, 3));
        8: u[DPP +: 8] = 8'h00;
        9: u[DPP +: 8] = 8'h03;
        10: begin d[79:72] = 8'h02; d[63:48] = 16'hFF00 | 16'($urandom_range(0, 255)); end
        default: ;
      endcase
      send_pkt(d, u, $urandom_range(1, 4), 1'b1);
      rdy_pct = 50;
    end
    drain();

    // Reset in the middle of a packet
    d = mk_hdr(16'h0800, 4'd4, 8'h40, 16'hB1E6);
    send_beat(d, mk_user(8'h04), 1'b0);
    reset = 1'b1;
    rdy_chk = 0;
    @(posedge AXI_ACLK);
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    expq.delete();
    in_pkt = 0; m_ttl = 0; m_byp = 0;
    reset = 1'b0;
    @(posedge AXI_ACLK);
    #1;
    chk("midrst_s_tready", s_tready, 1);
    rdy_chk = 1;
    d = mk_hdr(16'h0800, 4'd4, 8'h30, 16'h0000);
    send_beat(d, mk_user(8'h10), 1'b1);
    chk("midrst_ttl", m_tdata[79:72], 8'h2F);
    chk("midrst_csum", m_tdata[63:48], 16'h0100);
    drain();
    chk("midrst_ttl_cnt", ttl_dec_count, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
